prbs_checker: RTL and testbench

- Serial PRBS receiver/checker; the far end of the team's Fibonacci LFSR pattern generator.
- Self-synchronises to an incoming LFSR bitstream with default polynomial x^4+x^3+1 (period 15) and declares lock.
- Once locked, free-runs a local reference, flags every bit error and keeps a saturating error count.
- Sits at the receive side of link/BIST loopback paths.

---
 rtl/prbs_checker.sv | 140 ++++++++++++++
 tb/tb_prbs_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to a Fibonacci LFSR bitstream, declares lock,
// then free-runs a local reference to flag bit errors and keep a saturating error count.
module prbs_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned TAP_A      = 3,
  parameter int unsigned TAP_B      = 2,
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {StSeed, StHunt, StLocked} state_e;

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_hist, w_hist_next;
  logic [FILL_W-1:0]  r_fill, w_fill_next;
  logic [MATCH_W-1:0] r_match, w_match_next;
  logic [MISS_W-1:0]  r_miss, w_miss_next;
  logic               r_err_pulse, w_err_pulse_next;
  logic               r_lock_lost, w_lock_lost_next;
  logic [CNT_W-1:0]   r_err_count, w_err_count_next;

  logic w_exp;
  logic w_mismatch;
  logic w_hist_zero;
  logic w_err;

  assign w_exp       = r_hist[TAP_A] ^ r_hist[TAP_B];
  assign w_mismatch  = bit_in ^ w_exp;
  assign w_hist_zero = (r_hist == '0);

  always_comb begin
    w_state_next     = r_state;
    w_hist_next      = r_hist;
    w_fill_next      = r_fill;
    w_match_next     = r_match;
    w_miss_next      = r_miss;
    w_err_pulse_next = 1'b0;
    w_lock_lost_next = 1'b0;
    w_err            = 1'b0;

    if (bit_valid) begin
      unique case (r_state)
        StSeed: begin
          w_hist_next = {r_hist[WIDTH-2:0], bit_in};
          if (r_fill == FILL_W'(WIDTH - 1)) begin
            w_state_next = StHunt;
            w_fill_next  = '0;
            w_match_next = '0;
          end else begin
            w_fill_next = r_fill + FILL_W'(1);
          end
        end
        StHunt: begin
          w_hist_next = {r_hist[WIDTH-2:0], bit_in};
          // An all-zero history would predict zeros forever, so it never counts as a match.
          if (!w_mismatch && !w_hist_zero) begin
            if (r_match == MATCH_W'(LOCK_CNT - 1)) begin
              w_state_next = StLocked;
              w_match_next = '0;
              w_miss_next  = '0;
            end else begin
              w_match_next = r_match + MATCH_W'(1);
            end
          end else begin
            w_match_next = '0;
          end
        end
        StLocked: begin
          // Shift the prediction, not the received bit, so a flipped bit costs one error only.
          w_hist_next = {r_hist[WIDTH-2:0], w_exp};
          if (w_mismatch) begin
            w_err_pulse_next = 1'b1;
            w_err            = 1'b1;
            if (r_miss == MISS_W'(UNLOCK_CNT - 1)) begin
              w_state_next     = StHunt;
              w_miss_next      = '0;
              w_match_next     = '0;
              w_lock_lost_next = 1'b1;
            end else begin
              w_miss_next = r_miss + MISS_W'(1);
            end
          end else begin
            w_miss_next = '0;
          end
        end
        default: w_state_next = StSeed;
      endcase
    end

    w_err_count_next = r_err_count;
    if (clr_cnt) begin
      w_err_count_next = '0;
    end else if (w_err && (r_err_count != '1)) begin
      w_err_count_next = r_err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StSeed;
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_miss      <= '0;
      r_err_pulse <= 1'b0;
      r_lock_lost <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_hist      <= w_hist_next;
      r_fill      <= w_fill_next;
      r_match     <= w_match_next;
      r_miss      <= w_miss_next;
      r_err_pulse <= w_err_pulse_next;
      r_lock_lost <= w_lock_lost_next;
      r_err_count <= w_err_count_next;
    end
  end

  assign locked    = (r_state == StLocked);
  assign err_pulse = r_err_pulse;
  assign lock_lost = r_lock_lost;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single error, lock loss/relock, clear, saturation,
// valid gaps, async reset and all-zero input; a second instance has a 2-bit counter.
module tb_prbs_checker;

  logic        clk;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic        lock_lost;
  logic [15:0] err_count;
  logic        sat_locked;
  logic        sat_err_pulse;
  logic        sat_lock_lost;
  logic [1:0]  sat_count;

  prbs_checker u_dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .lock_lost (lock_lost),
    .err_count (err_count)
  );

  prbs_checker #(.CNT_W(2)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr_cnt   (clr_cnt),
    .locked    (sat_locked),
    .err_pulse (sat_err_pulse),
    .lock_lost (sat_lock_lost),
    .err_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One period of the generator output from seed 0001.
  bit pat [15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int p;
  int n_vec;
  int n_bad;
  int pulses;
  int lk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic b, input logic v, input logic c);
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    clr_cnt   = c;
    @(posedge clk);
    #1;
    if (err_pulse) pulses++;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      send(pat[p], 1'b1, 1'b0);
      p = (p + 1) % 15;
    end
  endtask

  task automatic bad(input logic c);
    send(~pat[p], 1'b1, c);
    p = (p + 1) % 15;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    pulses    = 0;
    p         = 0;
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean stream: lock one cycle after the 12th valid bit.
    clean(11);
    chk("lock_after_11", locked, 0);
    clean(1);
    chk("lock_after_12", locked, 1);
    clean(100);
    chk("clean_pulses", pulses, 0);
    chk("clean_count", err_count, 0);

    // Single flipped bit.
    bad(1'b0);
    chk("single_pulse", err_pulse, 1);
    clean(1);
    chk("single_pulse_clear", err_pulse, 0);
    pulses = 0;
    clean(20);
    chk("single_no_more", pulses, 0);
    chk("single_count", err_count, 1);
    chk("single_locked", locked, 1);

    // Clear with no error, then loss of lock on an inverted stream.
    send(1'b0, 1'b0, 1'b1);
    chk("clr_count", err_count, 0);
    chk("clr_sat_count", sat_count, 0);
    for (int i = 0; i < 4; i++) begin
      bad(1'b0);
      chk("inv_pulse", err_pulse, 1);
      chk("inv_lock_lost", lock_lost, (i == 3) ? 1 : 0);
      chk("inv_locked", locked, (i < 3) ? 1 : 0);
    end
    send(1'b0, 1'b0, 1'b0);
    chk("lost_pulse_end", lock_lost, 0);
    chk("lost_count", err_count, 4);
    chk("lost_sat_count", sat_count, 3);
    clean(7);
    chk("relock_7", locked, 0);
    clean(1);
    chk("relock_8", locked, 1);
    chk("relock_count_held", err_count, 4);

    // Saturation of the 2-bit counter on a fifth error.
    bad(1'b0);
    clean(1);
    chk("fifth_count", err_count, 5);
    chk("fifth_sat_count", sat_count, 3);

    // clr_cnt wins over a same-cycle error.
    send(1'b0, 1'b0, 1'b1);
    chk("clr2_count", err_count, 0);
    repeat (3) begin
      bad(1'b0);
      clean(1);
    end
    chk("three_count", err_count, 3);
    bad(1'b1);
    chk("clr_err_pulse", err_pulse, 1);
    chk("clr_err_count", err_count, 0);
    clean(1);
    chk("clr_err_locked", locked, 1);

    // Asynchronous reset while locked with a count of 2.
    repeat (2) begin
      bad(1'b0);
      clean(1);
    end
    chk("pre_rst_count", err_count, 2);
    chk("pre_rst_locked", locked, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_count", err_count, 0);
    @(negedge clk);
    bit_valid = 1'b0;
    rst       = 1'b0;
    clean(11);
    chk("rst_relock_11", locked, 0);
    clean(1);
    chk("rst_relock_12", locked, 1);

    // Valid gaps: idle cycles carry misleading data that must be ignored.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      clean(1);
      send(~pat[p], 1'b0, 1'b0);
      send(~pat[p], 1'b0, 1'b0);
    end
    chk("gap_lock_11", locked, 0);
    clean(1);
    chk("gap_lock_12", locked, 1);
    send(~pat[p], 1'b0, 1'b0);
    chk("gap_idle_locked", locked, 1);
    chk("gap_idle_pulse", err_pulse, 0);

    // All-zero input never locks.
    do_reset();
    lk = 0;
    repeat (50) begin
      send(1'b0, 1'b1, 1'b0);
      if (locked) lk++;
    end
    chk("zero_locked_cycles", lk, 0);
    chk("zero_count", err_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
